data_arith_extend: RTL and testbench
====================================

DATA_ARITH_EXTEND -- requirements
Module: data_arith_extend

Interface
- REQ-001 Parameter IN_W, default 4: width of each input lane in bits; SHALL be >= 1.
- REQ-002 Parameter OUT_W, default 8: width of each output lane in bits; SHALL be >= 1.
- REQ-003 Parameter DEPTH, default 2: number of independent lanes; SHALL be >= 1.
- REQ-004 Port ctrl.Clock, input, 1 bit: the single clock, carried in the shared Control bundle (ctrl); all state updates on its rising edge.
- REQ-005 Port ctrl.Reset, input, 1 bit: reset in the Control bundle; synchronous, active-high.
- REQ-006 Port in, input, unpacked array [DEPTH-1:0] of IN_W bits: operand lanes.
- REQ-007 Port sign, input, 1 bit (SignedUnsigned type): Signed selects sign extension, Unsigned selects zero extension; applies to all lanes.
- REQ-008 Port out, output, unpacked array [DEPTH-1:0] of OUT_W bits: registered extended results.

Function
- REQ-009 Each lane k SHALL be processed independently; no lane affects another.
- REQ-010 OUT_W > IN_W, Signed: out[k] SHALL be in[k] with bit IN_W-1 replicated into bits OUT_W-1..IN_W.
- REQ-011 OUT_W > IN_W, Unsigned: out[k] SHALL be in[k] with bits OUT_W-1..IN_W cleared.
- REQ-012 OUT_W == IN_W: out[k] SHALL equal in[k], regardless of sign.
- REQ-013 OUT_W < IN_W: out[k] SHALL be the low OUT_W bits of in[k] (truncation), regardless of sign.
- REQ-014 Latency SHALL be exactly one clock: in and sign sampled at rising edge N appear on out after edge N and hold until the next edge.
- REQ-015 out SHALL be driven only from registers, with no combinational path from in or sign to out.
- REQ-016 There is no handshake or enable; every lane register SHALL load on every non-reset clock edge.
- REQ-017 A change of sign between edges SHALL affect only results registered on later edges, never results already on out.
- REQ-018 IN_W == 1, Signed: a 1 input SHALL produce all-ones and a 0 input all-zeros.

Reset
- REQ-019 While ctrl.Reset is 1 at a rising edge, every out[k] SHALL load all-zeros, regardless of in and sign.
- REQ-020 Reset has priority over data loading at the same edge.
- REQ-021 On the first edge with ctrl.Reset 0, the registers SHALL load the extension of the current inputs.
- REQ-022 Reset asserted mid-stream SHALL zero out at the next edge, with no retention of earlier results.

Structure
- REQ-023 The Control bundle type (Clock, Reset) and the SignedUnsigned type (Signed, Unsigned) SHALL come from the shared package/header set; this block SHALL NOT redefine them.
- REQ-024 Combinational extension SHALL live in one sub-module, data_arith_extend_lane (IN_W, OUT_W parameters; in, sign, out), instantiated DEPTH times by a generate loop.
- REQ-025 The top module SHALL hold only the DEPTH output registers and the reset logic.

Verification
- REQ-026 Reset: Reset=1 for one edge with in={0,0} -> out={0x00,0x00}; any prior non-zero out is cleared.
- REQ-027 Signed extension: sign=Signed, in[0]=0xA, in[1]=0x5 -> one edge later out[0]=0xFA, out[1]=0x05.
- REQ-028 Unsigned extension: sign=Unsigned, in[0]=0xA, in[1]=0x5 -> one edge later out[0]=0x0A, out[1]=0x05.
- REQ-029 Latency/hold: in returns to {0,0} after the REQ-027 edge -> out stays {0xFA,0x05} until the next edge, then becomes {0x00,0x00}.
- REQ-030 Reset priority: Reset=1 with in[0]=0xF, Signed -> out[0]=0x00; release Reset -> next edge out[0]=0xFF.
- REQ-031 Width corners: IN_W=OUT_W=4, in=0xA, Signed -> 0xA; IN_W=8, OUT_W=4, in=0xA5 -> 0x5.

Source files
------------

// File: rtl/data_arith_extend_pkg.sv
// Shared types for the data_arith_extend block: the Control bundle and the
// signed/unsigned selector used by every lane.
package data_arith_extend_pkg;

    typedef struct packed {
        logic Clock;
        logic Reset;
    } ctrl_t;

    typedef enum logic {
        Unsigned = 1'b0,
        Signed   = 1'b1
    } sign_t;

endpackage

// File: rtl/data_arith_extend_lane.sv
// Combinational width adaptation of one lane: sign/zero extension when widening,
// pass-through when equal, truncation to the low bits when narrowing.
module data_arith_extend_lane
    import data_arith_extend_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  in,
    input  sign_t            sign,
    output logic [OUT_W-1:0] out
);

    generate
        if (OUT_W > IN_W) begin : g_extend
            logic w_fill;
            assign w_fill = (sign == Signed) & in[IN_W-1];
            assign out    = {{(OUT_W-IN_W){w_fill}}, in};
        end else if (OUT_W == IN_W) begin : g_pass
            // Sign has no effect when no bits are added.
            sign_t w_unused_sign;
            assign w_unused_sign = sign;
            assign out           = in;
        end else begin : g_trunc
            logic w_unused_bits;
            assign w_unused_bits = ^{sign, in[IN_W-1:OUT_W]};
            assign out           = in[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/data_arith_extend.sv
// DEPTH independent lanes, each extended combinationally and captured in an
// output register every clock; synchronous reset clears all lanes.
module data_arith_extend
    import data_arith_extend_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int DEPTH = 2
) (
    input  ctrl_t            ctrl,
    input  logic [IN_W-1:0]  in  [DEPTH-1:0],
    input  sign_t            sign,
    output logic [OUT_W-1:0] out [DEPTH-1:0]
);

    logic [OUT_W-1:0] w_ext     [DEPTH-1:0];
    logic [OUT_W-1:0] r_out_reg [DEPTH-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_lane
            data_arith_extend_lane #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_lane (
                .in   (in[gi]),
                .sign (sign),
                .out  (w_ext[gi])
            );

            // Reset wins over the load on the same edge.
            always_ff @(posedge ctrl.Clock) begin
                if (ctrl.Reset) begin
                    r_out_reg[gi] <= '0;
                end else begin
                    r_out_reg[gi] <= w_ext[gi];
                end
            end

            assign out[gi] = r_out_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_data_arith_extend.sv
// Self-checking bench: three width configurations (widen, equal, narrow)
// driven with directed and random stimulus against an arithmetic model.
module tb_data_arith_extend;
    import data_arith_extend_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    ctrl_t ctrl;
    sign_t sign = Signed;

    assign ctrl = '{Clock: clk, Reset: rst};
    always #5 clk = ~clk;

    logic [3:0] in_a  [1:0];
    logic [7:0] out_a [1:0];
    logic [3:0] in_b  [1:0];
    logic [3:0] out_b [1:0];
    logic [7:0] in_c  [1:0];
    logic [3:0] out_c [1:0];

    logic [7:0] exp_a [1:0];
    logic [3:0] exp_b [1:0];
    logic [3:0] exp_c [1:0];

    int total = 0;
    int bad   = 0;

    data_arith_extend #(.IN_W(4), .OUT_W(8), .DEPTH(2)) dut_a (
        .ctrl(ctrl), .in(in_a), .sign(sign), .out(out_a));
    data_arith_extend #(.IN_W(4), .OUT_W(4), .DEPTH(2)) dut_b (
        .ctrl(ctrl), .in(in_b), .sign(sign), .out(out_b));
    data_arith_extend #(.IN_W(8), .OUT_W(4), .DEPTH(2)) dut_c (
        .ctrl(ctrl), .in(in_c), .sign(sign), .out(out_c));

    // Interpret the input as a number (two's complement when signed), then
    // reduce it modulo 2**out_w.
    function automatic longint model(int in_w, int out_w, longint v, bit s);
        longint val = v;
        longint m   = longint'(1) << out_w;
        if (s && v >= (longint'(1) << (in_w - 1)))
            val = v - (longint'(1) << in_w);
        return ((val % m) + m) % m;
    endfunction

    task automatic compute_expected();
        for (int k = 0; k < 2; k++) begin
            exp_a[k] = rst ? 8'h0 : 8'(model(4, 8, longint'(in_a[k]), sign == Signed));
            exp_b[k] = rst ? 4'h0 : 4'(model(4, 4, longint'(in_b[k]), sign == Signed));
            exp_c[k] = rst ? 4'h0 : 4'(model(8, 4, longint'(in_c[k]), sign == Signed));
        end
    endtask

    task automatic check(string tag);
        for (int k = 0; k < 2; k++) begin
            total++;
            assert (out_a[k] === exp_a[k]) else begin
                bad++;
                $error("FAIL %s a[%0d]: got %h want %h", tag, k, out_a[k], exp_a[k]);
            end
            total++;
            assert (out_b[k] === exp_b[k]) else begin
                bad++;
                $error("FAIL %s b[%0d]: got %h want %h", tag, k, out_b[k], exp_b[k]);
            end
            total++;
            assert (out_c[k] === exp_c[k]) else begin
                bad++;
                $error("FAIL %s c[%0d]: got %h want %h", tag, k, out_c[k], exp_c[k]);
            end
        end
    endtask

    task automatic tick(string tag);
        compute_expected();
        @(posedge clk);
        #1;
        check(tag);
        $display("%s: rst=%0d sign=%0d a={%h,%h} b={%h,%h} c={%h,%h}", tag, rst, sign,
                 out_a[1], out_a[0], out_b[1], out_b[0], out_c[1], out_c[0]);
    endtask

    task automatic set_in(logic [3:0] a0, logic [3:0] a1, logic [7:0] c0, logic [7:0] c1);
        in_a[0] = a0; in_a[1] = a1;
        in_b[0] = a0; in_b[1] = a1;
        in_c[0] = c0; in_c[1] = c1;
    endtask

    initial begin
        // Reset has priority over non-zero inputs.
        rst = 1'b1; sign = Signed;
        set_in(4'hF, 4'h9, 8'hFF, 8'h3C);
        tick("reset_prio");

        rst = 1'b0;
        tick("first_load");

        // Reset clears a non-zero result.
        rst = 1'b1;
        set_in(4'h0, 4'h0, 8'h00, 8'h00);
        tick("reset_clear");

        rst = 1'b0; sign = Signed;
        set_in(4'hA, 4'h5, 8'hA5, 8'h5A);
        tick("signed");

        // Inputs and sign change between edges; out must hold.
        set_in(4'h0, 4'h0, 8'h00, 8'h00);
        sign = Unsigned;
        #1;
        check("hold");
        tick("after_hold");

        set_in(4'hA, 4'h5, 8'hA5, 8'h5A);
        tick("unsigned");

        rst = 1'b1; sign = Signed;
        set_in(4'hF, 4'h0, 8'h80, 8'h7F);
        tick("reset_prio2");
        rst = 1'b0;
        tick("release");

        for (int i = 0; i < 60; i++) begin
            rst  = ($urandom_range(0, 7) == 0);
            sign = sign_t'($urandom_range(0, 1));
            set_in(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
